// File: rtl/ahb_spi_master_slave.sv
// AHB-Lite MMIO responder with a byte-wide mode-0 SPI master for the boot flash.
// Registered address phase, zero-wait reads, two-cycle ERROR for bad accesses.
module ahb_spi_master_slave #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter logic [7:0]  CLKDIV_RESET = 8'd4
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  input  logic                  SPISDI,
  output logic                  SPISCLKO,
  output logic                  SPISDO,
  output logic                  SPISS,
  output logic                  IRQ
);

  localparam int unsigned OffW = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {StIdle, StShift, StDone} spi_state_e;

  logic            dp_valid_q, dp_write_q, err_q;
  logic [OffW-1:0] dp_off_q;
  logic [2:0]      ctrl_q;
  logic            rx_valid_q, overrun_q;
  logic [7:0]      rxdata_q, clkdiv_q;
  spi_state_e      state_q;
  logic [7:0]      shreg_q, div_cnt_q, cur_div_q;
  logic [3:0]      half_cnt_q;
  logic            sclk_q, rx_bit_q;

  logic sel_ctrl, sel_stat, sel_tx, sel_rx, sel_div, hit;
  logic busy, dp_err, tx_stall, wr_done, rd_done;
  logic ctrl_wr, stat_wr, tx_wr, div_wr, rx_rd, abort;
  logic unused_ok;

  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[1:0], HWDATA[31:8]};

  always_comb begin
    sel_ctrl  = dp_off_q == OffW'(0);
    sel_stat  = dp_off_q == OffW'(1);
    sel_tx    = dp_off_q == OffW'(2);
    sel_rx    = dp_off_q == OffW'(3);
    sel_div   = dp_off_q == OffW'(4);
    hit       = sel_ctrl | sel_stat | sel_tx | sel_rx | sel_div;
    busy      = state_q != StIdle;
    dp_err    = dp_valid_q && (!hit || (dp_write_q && sel_rx));
    tx_stall  = dp_valid_q && dp_write_q && sel_tx && busy;
    HREADYOUT = !((dp_err && !err_q) || tx_stall);
    HRESP     = dp_err;
    wr_done   = dp_valid_q && dp_write_q && !dp_err && !tx_stall;
    rd_done   = dp_valid_q && !dp_write_q && !dp_err;
    ctrl_wr   = wr_done && sel_ctrl;
    stat_wr   = wr_done && sel_stat;
    tx_wr     = wr_done && sel_tx;
    div_wr    = wr_done && sel_div;
    rx_rd     = rd_done && sel_rx;
    // Disabling while busy (or already disabled) drops the transfer immediately.
    abort     = busy && (!ctrl_q[0] || (ctrl_wr && !HWDATA[0]));
    HRDATA    = '0;
    if (rd_done) begin
      if (sel_ctrl)      HRDATA = {29'd0, ctrl_q};
      else if (sel_stat) HRDATA = {29'd0, overrun_q, rx_valid_q, busy};
      else if (sel_rx)   HRDATA = {24'd0, rxdata_q};
      else if (sel_div)  HRDATA = {24'd0, clkdiv_q};
    end
  end

  assign SPISCLKO = sclk_q;
  assign SPISDO   = shreg_q[7];
  assign SPISS    = ~ctrl_q[1];
  assign IRQ      = ctrl_q[2] & rx_valid_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_off_q   <= '0;
      err_q      <= 1'b0;
      ctrl_q     <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      rxdata_q   <= '0;
      clkdiv_q   <= CLKDIV_RESET;
      state_q    <= StIdle;
      shreg_q    <= '0;
      div_cnt_q  <= '0;
      cur_div_q  <= '0;
      half_cnt_q <= '0;
      sclk_q     <= 1'b0;
      rx_bit_q   <= 1'b0;
    end else begin
      if (HREADY) begin
        dp_valid_q <= HSEL & HTRANS[1];
        dp_write_q <= HWRITE;
        dp_off_q   <= HADDR[ADDR_WIDTH-1:2];
      end
      err_q <= dp_err & ~err_q;
      if (ctrl_wr) ctrl_q <= HWDATA[2:0];
      if (div_wr) clkdiv_q <= HWDATA[7:0];
      if (stat_wr && HWDATA[2]) overrun_q <= 1'b0;
      if (rx_rd) rx_valid_q <= 1'b0;
      if (abort) begin
        state_q <= StIdle;
        sclk_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (tx_wr && ctrl_q[0]) begin
              shreg_q    <= HWDATA[7:0];
              div_cnt_q  <= '0;
              half_cnt_q <= '0;
              cur_div_q  <= clkdiv_q;
              state_q    <= StShift;
            end
          end
          StShift: begin
            if (div_cnt_q == cur_div_q) begin
              div_cnt_q  <= '0;
              half_cnt_q <= half_cnt_q + 4'd1;
              sclk_q     <= ~sclk_q;
              // Sample on the rising edge, shift the sample in on the falling edge.
              if (!sclk_q) rx_bit_q <= SPISDI;
              else         shreg_q  <= {shreg_q[6:0], rx_bit_q};
              if (half_cnt_q == 4'd15) state_q <= StDone;
            end else begin
              div_cnt_q <= div_cnt_q + 8'd1;
            end
          end
          StDone: begin
            rxdata_q   <= shreg_q;
            rx_valid_q <= 1'b1;
            if (rx_valid_q) overrun_q <= 1'b1;
            state_q    <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_spi_master_slave.sv
// Directed + randomized bench for ahb_spi_master_slave with an SPI slave model and a
// register-level reference model (rx_valid / overrun / rxdata tracked in plain variables).
module tb_ahb_spi_master_slave;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic        SPISDI, SPISCLKO, SPISDO, SPISS, IRQ;

  ahb_spi_master_slave #(.ADDR_WIDTH(8), .CLKDIV_RESET(8'd4)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SPISDI(SPISDI),
    .SPISCLKO(SPISCLKO), .SPISDO(SPISDO), .SPISS(SPISS), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  int n_cmp = 0;
  int n_bad = 0;

  // SPI line monitor and slave
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  logic mosi_log [0:1023];
  time  rise_t   [0:1023];
  time  fall_t   [0:1023];
  int         fall_base;
  logic [7:0] slv_byte;
  logic       loopback;

  always @(posedge SPISCLKO) begin
    mosi_log[rise_cnt[9:0]] <= SPISDO;
    rise_t[rise_cnt[9:0]]   <= $time;
    rise_cnt                <= rise_cnt + 1;
  end

  always @(negedge SPISCLKO) begin
    fall_t[fall_cnt[9:0]] <= $time;
    fall_cnt              <= fall_cnt + 1;
  end

  function automatic logic slave_bit(input logic [7:0] b, input int i);
    logic [7:0] t;
    if (i < 0 || i > 7) return 1'b0;
    t = b << i;
    return t[7];
  endfunction

  assign SPISDI = loopback ? SPISDO : slave_bit(slv_byte, fall_cnt - fall_base);

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] b = 8'd0;
    for (int k = 0; k < 8; k++) begin
      int j = base + k;
      b = {b[6:0], mosi_log[j[9:0]]};
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Results of the last bus transfer
  logic [31:0] x_rdata;
  logic        x_resp, x_rdy0, x_resp0;
  int          x_waits;

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    bit done = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 8'h00; HWRITE = 1'b0; HWDATA = wdata;
    x_waits = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge HCLK);
      if (i == 0) begin
        x_rdy0  = HREADYOUT;
        x_resp0 = HRESP;
      end
      if (HREADYOUT) begin
        x_rdata = HRDATA;
        x_resp  = HRESP;
        done    = 1'b1;
      end else begin
        x_waits++;
      end
      @(posedge HCLK); #1;
    end
    if (!done) check("bus_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic rd_chk(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    xfer(1'b0, addr, 32'd0);
    check(tag, x_rdata, exp);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      xfer(1'b0, 8'h04, 32'd0);
      if (!x_rdata[0]) idle = 1'b1;
    end
    check("idle_timeout", {31'd0, idle}, 32'd1);
  endtask

  task automatic spi_run(input logic [7:0] tx, input logic [7:0] slave, input int d,
                         input string tag);
    int  rb, fb7;
    time dt;
    slv_byte  = slave;
    rb        = rise_cnt;
    fall_base = fall_cnt;
    fb7       = fall_cnt + 7;
    xfer(1'b1, 8'h08, {24'd0, tx});
    check({tag, "_tx_resp"}, {31'd0, x_resp}, 32'd0);
    wait_idle();
    check({tag, "_rises"}, rise_cnt - rb, 32'd8);
    check({tag, "_mosi"}, {24'd0, mosi_byte(rb)}, {24'd0, tx});
    dt = fall_t[fb7[9:0]] - rise_t[rb[9:0]];
    check({tag, "_sclk_span"}, 32'(dt), 32'(150 * (d + 1)));
  endtask

  logic [7:0] m_rx;
  logic       m_valid, m_ovr;
  int         rb0, cnt0;

  initial begin
    HRESETN = 1'b0; HSEL = 1'b0; HADDR = 8'h00; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HWDATA = 32'd0; loopback = 1'b1; slv_byte = 8'h00; fall_base = 0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hresp", {31'd0, HRESP}, 32'd0);
    check("rst_hrdata", HRDATA, 32'd0);
    check("rst_sclk", {31'd0, SPISCLKO}, 32'd0);
    check("rst_sdo", {31'd0, SPISDO}, 32'd0);
    check("rst_ss", {31'd0, SPISS}, 32'd1);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    HRESETN = 1'b1;
    rd_chk(8'h00, 32'd0, "rst_ctrl");
    rd_chk(8'h04, 32'd0, "rst_status");
    rd_chk(8'h10, 32'd4, "rst_clkdiv");
    rd_chk(8'h0C, 32'd0, "rst_rxdata");

    // Loopback transfer at the fastest clock
    xfer(1'b1, 8'h00, 32'h3);
    check("ss_asserted", {31'd0, SPISS}, 32'd0);
    xfer(1'b1, 8'h10, 32'h0);
    rd_chk(8'h10, 32'd0, "clkdiv_rw");
    rd_chk(8'h08, 32'd0, "txdata_reads_zero");
    spi_run(8'hA5, 8'h00, 0, "loop_a5");
    rd_chk(8'h04, 32'h2, "loop_status");
    rd_chk(8'h0C, 32'hA5, "loop_rxdata");
    rd_chk(8'h04, 32'h0, "loop_status_cleared");

    // Back-to-back TXDATA writes: second one stalls for the whole first transfer
    rb0 = rise_cnt;
    xfer(1'b1, 8'h08, 32'h3C);
    check("b2b_first_waits", x_waits, 32'd0);
    xfer(1'b1, 8'h08, 32'hC3);
    check("b2b_second_waits", x_waits, 32'd15);
    check("b2b_second_resp", {31'd0, x_resp}, 32'd0);
    wait_idle();
    check("b2b_rises", rise_cnt - rb0, 32'd16);
    check("b2b_byte0", {24'd0, mosi_byte(rb0)}, 32'h3C);
    check("b2b_byte1", {24'd0, mosi_byte(rb0 + 8)}, 32'hC3);
    rd_chk(8'h04, 32'h6, "b2b_overrun");
    xfer(1'b1, 8'h04, 32'h4);
    rd_chk(8'h04, 32'h2, "w1c_overrun");
    rd_chk(8'h0C, 32'hC3, "b2b_rxdata");

    // Interrupt on completion, cleared by the RXDATA read
    loopback = 1'b0;
    xfer(1'b1, 8'h00, 32'h7);
    check("irq_idle", {31'd0, IRQ}, 32'd0);
    m_rx = 8'($urandom);
    spi_run(8'($urandom), m_rx, 0, "irq_xfer");
    check("irq_set", {31'd0, IRQ}, 32'd1);
    rd_chk(8'h0C, {24'd0, m_rx}, "irq_rxdata");
    check("irq_cleared", {31'd0, IRQ}, 32'd0);

    // ERROR responses leave registers alone
    xfer(1'b0, 8'h14, 32'd0);
    check("err_rd_rdy0", {31'd0, x_rdy0}, 32'd0);
    check("err_rd_resp0", {31'd0, x_resp0}, 32'd1);
    check("err_rd_resp1", {31'd0, x_resp}, 32'd1);
    check("err_rd_waits", x_waits, 32'd1);
    xfer(1'b1, 8'h0C, 32'h5A);
    check("err_wr_rdy0", {31'd0, x_rdy0}, 32'd0);
    check("err_wr_resp1", {31'd0, x_resp}, 32'd1);
    check("err_wr_waits", x_waits, 32'd1);
    xfer(1'b1, 8'h14, 32'hFF);
    check("err_wr14_resp1", {31'd0, x_resp}, 32'd1);
    rd_chk(8'h00, 32'h7, "err_ctrl_kept");
    rd_chk(8'h10, 32'h0, "err_clkdiv_kept");
    rd_chk(8'h0C, {24'd0, m_rx}, "err_rxdata_kept");
    rd_chk(8'h04, 32'h0, "err_status_kept");

    // Randomized transfers against the status model
    m_valid = 1'b0; m_ovr = 1'b0;
    for (int it = 0; it < 6; it++) begin
      int d = int'($urandom_range(0, 3));
      logic [7:0] tx, sl;
      tx = 8'($urandom); sl = 8'($urandom);
      xfer(1'b1, 8'h10, 32'(d));
      spi_run(tx, sl, d, "rnd");
      m_ovr = m_ovr | m_valid; m_valid = 1'b1; m_rx = sl;
      check("rnd_irq", {31'd0, IRQ}, {31'd0, m_valid});
      rd_chk(8'h04, {29'd0, m_ovr, m_valid, 1'b0}, "rnd_status");
      if ($urandom_range(0, 1) == 1) begin
        rd_chk(8'h0C, {24'd0, m_rx}, "rnd_rxdata");
        m_valid = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        xfer(1'b1, 8'h04, 32'h4);
        m_ovr = 1'b0;
      end
    end

    // CLKDIV written mid-transfer applies only to the next transfer
    loopback = 1'b1;
    xfer(1'b1, 8'h10, 32'h1);
    rb0 = rise_cnt; cnt0 = fall_cnt + 7;
    xfer(1'b1, 8'h08, 32'h96);
    xfer(1'b1, 8'h10, 32'h3);
    check("div_mid_waits", x_waits, 32'd0);
    wait_idle();
    check("div_mid_span", 32'(fall_t[cnt0[9:0]] - rise_t[rb0[9:0]]), 32'd300);
    check("div_mid_mosi", {24'd0, mosi_byte(rb0)}, 32'h96);
    rd_chk(8'h10, 32'h3, "div_mid_new");
    m_ovr = m_ovr | m_valid; m_valid = 1'b1; m_rx = 8'h96;

    // Abort by clearing enable after the third rising edge
    xfer(1'b1, 8'h10, 32'h1);
    rb0 = rise_cnt;
    xfer(1'b1, 8'h08, 32'h5B);
    for (int i = 0; i < 200 && rise_cnt < rb0 + 3; i++) @(posedge HCLK);
    check("abort_reach_bit3", {31'd0, rise_cnt >= rb0 + 3}, 32'd1);
    #1;
    xfer(1'b1, 8'h00, 32'h6);
    check("abort_sclk", {31'd0, SPISCLKO}, 32'd0);
    cnt0 = rise_cnt;
    rd_chk(8'h04, {29'd0, m_ovr, m_valid, 1'b0}, "abort_status");
    repeat (40) @(posedge HCLK);
    #1;
    check("abort_no_more_sclk", rise_cnt - cnt0, 32'd0);
    rd_chk(8'h0C, {24'd0, m_rx}, "abort_rxdata_kept");

    // TXDATA write with enable=0 is accepted and ignored
    cnt0 = rise_cnt;
    xfer(1'b1, 8'h08, 32'hFF);
    check("dis_tx_resp", {31'd0, x_resp}, 32'd0);
    repeat (40) @(posedge HCLK);
    #1;
    check("dis_tx_no_sclk", rise_cnt - cnt0, 32'd0);
    rd_chk(8'h04, {29'd0, m_ovr, 2'b00}, "dis_tx_status");

    // Reset in the middle of a transfer
    xfer(1'b1, 8'h00, 32'h3);
    rb0 = rise_cnt;
    xfer(1'b1, 8'h08, 32'hE7);
    for (int i = 0; i < 200 && rise_cnt < rb0 + 2; i++) @(posedge HCLK);
    check("rst_mid_reach", {31'd0, rise_cnt >= rb0 + 2}, 32'd1);
    #1;
    HRESETN = 1'b0;
    @(posedge HCLK); #1;
    check("rst_mid_sclk", {31'd0, SPISCLKO}, 32'd0);
    check("rst_mid_ss", {31'd0, SPISS}, 32'd1);
    check("rst_mid_irq", {31'd0, IRQ}, 32'd0);
    HRESETN = 1'b1;
    rd_chk(8'h04, 32'd0, "rst_mid_status");
    rd_chk(8'h00, 32'd0, "rst_mid_ctrl");
    rd_chk(8'h10, 32'd4, "rst_mid_clkdiv");
    rd_chk(8'h0C, 32'd0, "rst_mid_rxdata");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
